// File: rtl/bch_frame_arbiter.sv
// Two-source serial arbiter feeding one BCH(63,51) encoder, one K-bit block per grant.
// Define BCH_ARB_FIXED_PRIO_EN for fixed priority (source 0 wins ties); default is round-robin.
module bch_frame_arbiter #(
  parameter int unsigned K = 51
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in0,
  input  logic       valid_in1,
  input  logic       data_in0,
  input  logic       data_in1,
  output logic       ready_in0,
  output logic       ready_in1,
  output logic       enc_valid,
  output logic       enc_data,
  input  logic       enc_ready,
  output logic [1:0] grant,
  output logic       frame_done,
  output logic       frame_src
);

  typedef enum logic [1:0] {IDLE, ARB, XFER, DRAIN} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [5:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       src_q, src_d;
  logic       sel;
  logic       tie_winner;
  logic       winner;

`ifdef BCH_ARB_FIXED_PRIO_EN
  assign tie_winner = 1'b0;
`else
  logic last_q, last_d;
  assign tie_winner = ~last_q;
`endif

  assign sel    = grant_q[1];
  assign winner = (valid_in0 & valid_in1) ? tie_winner : valid_in1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    src_d     = src_q;
`ifndef BCH_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    enc_valid = 1'b0;
    enc_data  = 1'b0;
    ready_in0 = 1'b0;
    ready_in1 = 1'b0;
    case (state_q)
      IDLE: state_d = ARB;
      ARB: begin
        if (valid_in0 | valid_in1) begin
          grant_d = winner ? 2'b10 : 2'b01;
          state_d = XFER;
        end
      end
      XFER: begin
        // Only the granted source sees enc_ready; the other is held off entirely.
        enc_valid = sel ? valid_in1 : valid_in0;
        enc_data  = sel ? data_in1 : data_in0;
        ready_in0 = ~sel & enc_ready;
        ready_in1 = sel & enc_ready;
        if (enc_valid & enc_ready) begin
          if (cnt_q == 6'(K - 1)) begin
            cnt_d   = '0;
            grant_d = '0;
            done_d  = 1'b1;
            src_d   = sel;
`ifndef BCH_ARB_FIXED_PRIO_EN
            last_d  = sel;
`endif
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      DRAIN: begin
        if (enc_ready) state_d = ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      src_q   <= 1'b0;
`ifndef BCH_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      src_q   <= src_d;
`ifndef BCH_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign frame_done = done_q;
  assign frame_src  = src_q;

endmodule

// File: tb/tb_bch_frame_arbiter.sv
// Bench for bch_frame_arbiter: per-cycle model comparison plus hand-computed timing/sequence checks.
module tb_bch_frame_arbiter;
  localparam int K = 51;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in0 = 1'b0, valid_in1 = 1'b0;
  logic       data_in0 = 1'b0, data_in1 = 1'b0;
  logic       enc_ready = 1'b1;
  logic       ready_in0, ready_in1, enc_valid, enc_data;
  logic [1:0] grant;
  logic       frame_done, frame_src;

  bch_frame_arbiter #(.K(K)) dut (
    .clk(clk), .rst(rst),
    .valid_in0(valid_in0), .valid_in1(valid_in1),
    .data_in0(data_in0), .data_in1(data_in1),
    .ready_in0(ready_in0), .ready_in1(ready_in1),
    .enc_valid(enc_valid), .enc_data(enc_data), .enc_ready(enc_ready),
    .grant(grant), .frame_done(frame_done), .frame_src(frame_src)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rel = 0;
  int gq[$], gcq[$], dq[$], dsq[$];

  // Model of the block's observable behaviour; phase: 0 idle, 1 arbitrate, 2 transfer, 3 drain.
  bit         m_ok = 1'b0;
  int         m_phase = 0;
  logic [1:0] m_grant = '0;
  int         m_bits = 0;
  logic       m_done = 1'b0, m_src = 1'b0, m_last = 1'b1;
  logic       exp_v, g;
  logic [1:0] prev_g = 2'bxx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999;
  endfunction

  function automatic logic pick_winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
`ifdef BCH_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return (last == 1'b1) ? 1'b0 : 1'b1;
`endif
    end
    return v1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    data_in0 = 1'($urandom);
    data_in1 = 1'($urandom);
  end

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      exp_v = (m_grant == 2'b01) ? valid_in0 : (m_grant == 2'b10) ? valid_in1 : 1'b0;
      check("grant", 32'(grant), 32'(m_grant));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("frame_src", 32'(frame_src), 32'(m_src));
      check("enc_valid", 32'(enc_valid), 32'(exp_v));
      check("ready_in0", 32'(ready_in0), 32'((m_grant == 2'b01) & enc_ready));
      check("ready_in1", 32'(ready_in1), 32'((m_grant == 2'b10) & enc_ready));
      if (exp_v) check("enc_data", 32'(enc_data), 32'(m_grant[1] ? data_in1 : data_in0));
    end
    if (frame_done === 1'b1) begin
      dq.push_back(cyc);
      dsq.push_back(int'(frame_src));
    end
    if (grant !== 2'b00 && prev_g === 2'b00) begin
      gq.push_back(int'(grant));
      gcq.push_back(cyc);
    end
    prev_g = grant;
    if (rst) begin
      m_ok = 1'b1; m_phase = 0; m_grant = '0; m_bits = 0;
      m_done = 1'b0; m_src = 1'b0; m_last = 1'b1;
    end else if (m_ok) begin
      m_done = 1'b0;
      case (m_phase)
        0: m_phase = 1;
        1: if (valid_in0 || valid_in1) begin
             m_grant = pick_winner(valid_in0, valid_in1, m_last) ? 2'b10 : 2'b01;
             m_phase = 2;
           end
        2: begin
             g = m_grant[1];
             if ((g ? valid_in1 : valid_in0) && enc_ready) begin
               m_bits++;
               if (m_bits == K) begin
                 m_bits = 0; m_grant = '0; m_done = 1'b1;
                 m_src = g; m_last = g; m_phase = 3;
               end
             end
           end
        default: if (enc_ready) m_phase = 1;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    rel = cyc;
    gq.delete(); gcq.delete(); dq.delete(); dsq.delete();
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int t = 0;
    while (dq.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    check(name, 32'(dq.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // Single source, encoder always ready.
    valid_in0 = 1'b1;
    tick(1);
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_src", 32'(frame_src), 32'd0);
    check("rst_ready", 32'({ready_in0, ready_in1, enc_valid}), 32'd0);
    wait_frames(1, 200, "s1_timeout");
    valid_in0 = 1'b0;
    tick(3);
    check("s1_grants", 32'(gq.size()), 32'd1);
    check("s1_grant_val", 32'(qget(gq, 0)), 32'd1);
    check("s1_grant_lat", 32'(qget(gcq, 0) - rel), 32'd2);
    check("s1_done_cnt", 32'(dq.size()), 32'd1);
    check("s1_done_lat", 32'(qget(dq, 0) - rel), 32'd53);
    check("s1_done_src", 32'(qget(dsq, 0)), 32'd0);

    // Both sources requesting continuously.
    valid_in0 = 1'b1; valid_in1 = 1'b1;
    do_reset();
    wait_frames(4, 400, "s2_timeout");
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    tick(3);
    check("s2_grants", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef BCH_ARB_FIXED_PRIO_EN
      check("s2_grant_seq", 32'(qget(gq, i)), 32'd1);
      check("s2_src_seq", 32'(qget(dsq, i)), 32'd0);
`else
      check("s2_grant_seq", 32'(qget(gq, i)), (i % 2 == 0) ? 32'd1 : 32'd2);
      check("s2_src_seq", 32'(qget(dsq, i)), 32'(i % 2));
`endif
    end

    // Source 0 stalls for 5 cycles with 20 bits already accepted.
    valid_in0 = 1'b1;
    do_reset();
    tick(22);
    valid_in0 = 1'b0;
    tick(5);
    valid_in0 = 1'b1;
    wait_frames(1, 200, "s3_timeout");
    valid_in0 = 1'b0;
    tick(3);
    check("s3_grants", 32'(gq.size()), 32'd1);
    check("s3_done_lat", 32'(qget(dq, 0) - rel), 32'd58);

    // Encoder busy for 13 cycles after the last message bit.
    valid_in0 = 1'b1;
    do_reset();
    tick(53);
    enc_ready = 1'b0;
    tick(13);
    enc_ready = 1'b1;
    tick(3);
    check("s4_done_lat", 32'(qget(dq, 0) - rel), 32'd53);
    check("s4_grants", 32'(gq.size()), 32'd2);
    check("s4_regrant_lat", 32'(qget(gcq, 1) - rel), 32'd68);

    // Reset in the middle of a source-1 block.
    valid_in0 = 1'b0; valid_in1 = 1'b1;
    do_reset();
    tick(32);
    check("s5_first_grant", 32'(qget(gq, 0)), 32'd2);
    rst = 1'b1;
    tick(2);
    check("s5_no_done", 32'(dq.size()), 32'd0);
    valid_in0 = 1'b1;
    do_reset();
    wait_frames(1, 200, "s5_timeout");
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    tick(3);
    check("s5_tie_grant", 32'(qget(gq, 0)), 32'd1);
    check("s5_done_lat", 32'(qget(dq, 0) - rel), 32'd53);
    check("s5_done_src", 32'(qget(dsq, 0)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bch_frame_arbiter.md
BCH_FRAME_ARBITER -- requirements
Module: bch_frame_arbiter

Interface
REQ-001 SHALL have parameter K, default 51: message bits per BCH(63,51) block.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports valid_in0, valid_in1  input  1 each: source bit valid.
REQ-005 SHALL have ports data_in0, data_in1  input  1 each: source serial bit.
REQ-006 SHALL have ports ready_in0, ready_in1  output  1 each: source bit accepted when ready and valid are both high.
REQ-007 SHALL have port enc_valid  output  1: bit valid to the encoder.
REQ-008 SHALL have port enc_data  output  1: bit to the encoder.
REQ-009 SHALL have port enc_ready  input  1: encoder ready_in.
REQ-010 SHALL have port grant  output  2: one-hot registered grant.
REQ-011 SHALL have port frame_done  output  1: one-cycle pulse when a block's K-th bit is accepted.
REQ-012 SHALL have port frame_src  output  1: source index of the last completed block.

Function
REQ-013 SHALL implement states IDLE, ARB, XFER, DRAIN.
REQ-014 IDLE SHALL go to ARB unconditionally on the next cycle.
REQ-015 In ARB, if any valid_inN is high, the block SHALL register the winner into grant and go to XFER the next cycle; otherwise it SHALL stay in ARB with grant=00.
REQ-016 Arbitration SHALL be round-robin per block: on a simultaneous request, the source not served last wins; a lone requester always wins.
REQ-017 In XFER, the path SHALL be combinational: enc_valid = valid_inG, enc_data = data_inG, ready_inG = enc_ready, ready_in of the other source = 0.
REQ-018 Outside XFER, enc_valid, ready_in0 and ready_in1 SHALL be 0.
REQ-019 A 6-bit counter SHALL increment on each enc_valid&enc_ready handshake in XFER.
REQ-020 The counter SHALL not change on a cycle with no handshake; a source dropping valid mid-block stalls the block with the grant held and no timeout.
REQ-021 On the handshake at count K-1, the block SHALL, on the next edge: clear the counter, set grant=00, pulse frame_done, load frame_src, update the last-served pointer and enter DRAIN.
REQ-022 DRAIN SHALL hold until enc_ready=1 (encoder finished the parity phase), then go to ARB.
REQ-023 DRAIN SHALL therefore last at least 1 cycle; during it, sources are never ready.
REQ-024 Exactly K bits per grant SHALL reach the encoder; no bit from the non-granted source SHALL ever be forwarded.

Reset
REQ-025 When rst is high at a rising edge, the block SHALL enter IDLE, set the counter to 0, and set grant=00, frame_done=0 and frame_src=0.
REQ-026 Reset SHALL set the last-served pointer to 1 so that source 0 wins the first tie.
REQ-027 Reset mid-block SHALL abandon the partial block with no frame_done; the encoder is reset by the same rst.

Configuration
REQ-028 Macro BCH_ARB_FIXED_PRIO_EN defined: arbitration SHALL be fixed priority, with source 0 always winning a tie; the last-served pointer is unused.
REQ-029 Macro BCH_ARB_FIXED_PRIO_EN undefined: arbitration SHALL be round-robin per REQ-016.

Verification
REQ-030 Reset then valid_in0 only, enc_ready=1: grant=01 two cycles after reset release; 51 bits forwarded; frame_done pulses once with frame_src=0; grant=00 in DRAIN.
REQ-031 Both sources valid continuously, round-robin: grants go 01,10,01,10; each block is 51 bits; frame_src sequence is 0,1,0,1.
REQ-032 Same stimulus with BCH_ARB_FIXED_PRIO_EN defined: every grant = 01, and source 1 is never ready.
REQ-033 Source 0 drops valid for 5 cycles at bit 20: counter holds at 20, grant stays 01, the block completes with exactly 51 forwarded bits and frame_done asserts 5 cycles later than the unstalled case.
REQ-034 enc_ready low for 13 cycles after the 51st bit: state stays DRAIN with ready_in0=ready_in1=0, and ARB is entered the cycle after enc_ready returns high.
REQ-035 rst asserted at bit 30 of a source-1 block: no frame_done; after release, a tie is won by source 0 and the new block counts from 0.
